// File: rtl/truth_table_sweeper.sv
// Sweeps every input combination of a 2..4-input combinational function, captures its output
// into a truth-table word and compares it with a latched expected table.
module truth_table_sweeper #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_y,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_fail,
  output logic                 pass
);

  localparam int unsigned T           = 2 ** N_IN;
  localparam int unsigned CntW        = N_IN + 1;
  localparam int unsigned SettleLastI = (SETTLE == 0) ? 0 : SETTLE - 1;
  localparam logic [3:0]  SettleLast  = SettleLastI[3:0];
  localparam logic [N_IN-1:0] StimLast = {N_IN{1'b1}};

  typedef enum logic [1:0] {StIdle, StWait, StSample, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        settle_q, settle_d;
  logic [T-1:0]      exp_q, exp_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [T-1:0]      table_q, table_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0]   ff_q, ff_d;
  logic              pass_q, pass_d;

  // With SETTLE=0 the wait state is bypassed entirely.
  state_e            after_stim;
  assign after_stim = (SETTLE == 0) ? StSample : StWait;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    exp_d    = exp_q;
    stim_d   = stim_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    table_d  = table_q;
    cnt_d    = cnt_q;
    ff_d     = ff_q;
    pass_d   = pass_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          exp_d    = expected;
          table_d  = '0;
          cnt_d    = '0;
          ff_d     = '0;
          pass_d   = 1'b0;
          stim_d   = '0;
          settle_d = '0;
          busy_d   = 1'b1;
          state_d  = after_stim;
        end
      end
      StWait: begin
        if (settle_q == SettleLast) begin
          state_d = StSample;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StSample: begin
        table_d[stim_q] = dut_y;
        if (dut_y != exp_q[stim_q]) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == '0) begin
            ff_d = stim_q;
          end
        end
        if (stim_q == StimLast) begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = (cnt_d == '0);
        end else begin
          stim_d   = stim_q + N_IN'(1);
          settle_d = '0;
          state_d  = after_stim;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      settle_q <= '0;
      exp_q    <= '0;
      stim_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      table_q  <= '0;
      cnt_q    <= '0;
      ff_q     <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      exp_q    <= exp_d;
      stim_q   <= stim_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      table_q  <= table_d;
      cnt_q    <= cnt_d;
      ff_q     <= ff_d;
      pass_q   <= pass_d;
    end
  end

  assign stim         = stim_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign mismatch_cnt = cnt_q;
  assign first_fail   = ff_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: table of sweeps on a SETTLE=1 instance plus start-hold and reset corner
// cases on a SETTLE=0 instance.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        reset;

  logic        start0, y0, busy0, done0, pass0;
  logic [15:0] exp0, tbl0;
  logic [3:0]  stim0, ff0;
  logic [4:0]  cnt0;
  int          mode;

  logic        start1, y1, busy1, done1, pass1;
  logic [15:0] exp1, tbl1;
  logic [3:0]  stim1, ff1;
  logic [4:0]  cnt1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(4), .SETTLE(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .expected(exp0), .dut_y(y0),
    .stim(stim0), .busy(busy0), .done(done0), .table_out(tbl0),
    .mismatch_cnt(cnt0), .first_fail(ff0), .pass(pass0)
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE(0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .expected(exp1), .dut_y(y1),
    .stim(stim1), .busy(busy1), .done(done1), .table_out(tbl1),
    .mismatch_cnt(cnt1), .first_fail(ff1), .pass(pass1)
  );

  // Functions under test; s = {A,B,C,D}.
  function automatic logic fut(input int m, input logic [3:0] s);
    case (m)
      0:       return ~s[2];
      1:       return 1'b0;
      2:       return s[0];
      3:       return s[3] & s[2];
      4:       return ^s;
      default: return 1'b1;
    endcase
  endfunction

  always_comb y0 = fut(mode, stim0);
  always_comb y1 = ~stim1[2];

  typedef struct {
    int          mode;
    logic [15:0] expv;
    logic [15:0] tbl;
    int          cnt;
    int          ff;
    logic        pass;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic run_vec(input int i);
    int lat;
    mode = vecs[i].mode;
    @(negedge clk);
    exp0   = vecs[i].expv;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    exp0   = ~vecs[i].expv;  // must not affect the running sweep
    chk("busy_at_accept", 32'(busy0), 32'd1);
    chk("pass_cleared", 32'(pass0), 32'd0);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (done0) begin
        lat = c;
        break;
      end
    end
    chk("done_latency", 32'(lat), 32'd32);
    chk("busy_at_done", 32'(busy0), 32'd1);
    chk("table_out", 32'(tbl0), 32'(vecs[i].tbl));
    chk("mismatch_cnt", 32'(cnt0), 32'(vecs[i].cnt));
    chk("first_fail", 32'(ff0), 32'(vecs[i].ff));
    chk("pass", 32'(pass0), 32'(vecs[i].pass));
    chk("stim_last", 32'(stim0), 32'd15);
    @(posedge clk);
    #1;
    chk("done_pulse_end", 32'(done0), 32'd0);
    chk("busy_end", 32'(busy0), 32'd0);
    chk("pass_hold", 32'(pass0), 32'(vecs[i].pass));
    chk("table_hold", 32'(tbl0), 32'(vecs[i].tbl));
    chk("stim_hold", 32'(stim0), 32'd15);
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_stim"}, 32'(stim0), 32'd0);
    chk({tag, "_busy"}, 32'(busy0), 32'd0);
    chk({tag, "_done"}, 32'(done0), 32'd0);
    chk({tag, "_table"}, 32'(tbl0), 32'd0);
    chk({tag, "_cnt"}, 32'(cnt0), 32'd0);
    chk({tag, "_ff"}, 32'(ff0), 32'd0);
    chk({tag, "_pass"}, 32'(pass0), 32'd0);
  endtask

  initial begin
    int  dcount;
    logic want_busy, want_done;

    vecs[0] = '{mode: 0, expv: 16'h0F0F, tbl: 16'h0F0F, cnt: 0,  ff: 0,  pass: 1'b1};
    vecs[1] = '{mode: 0, expv: 16'h0F0E, tbl: 16'h0F0F, cnt: 1,  ff: 0,  pass: 1'b0};
    vecs[2] = '{mode: 1, expv: 16'hFFFF, tbl: 16'h0000, cnt: 16, ff: 0,  pass: 1'b0};
    vecs[3] = '{mode: 2, expv: 16'hAA2A, tbl: 16'hAAAA, cnt: 1,  ff: 7,  pass: 1'b0};
    vecs[4] = '{mode: 3, expv: 16'h7000, tbl: 16'hF000, cnt: 1,  ff: 15, pass: 1'b0};
    vecs[5] = '{mode: 4, expv: 16'h6990, tbl: 16'h6996, cnt: 2,  ff: 1,  pass: 1'b0};
    vecs[6] = '{mode: 5, expv: 16'h0000, tbl: 16'hFFFF, cnt: 16, ff: 0,  pass: 1'b0};

    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    exp0   = '0;
    exp1   = 16'h0F0F;
    mode   = 0;
    #1;
    chk_zero0("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Asynchronous reset between edges clears held results immediately.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_zero0("async_rst");
    @(negedge clk);
    reset = 1'b0;

    // SETTLE=0 instance with start held high for 40 edges, then a stray mid-sweep pulse.
    @(posedge clk);
    #1;
    start1 = 1'b1;
    for (int e = 0; e <= 60; e++) begin
      @(posedge clk);
      #1;
      want_busy = (e <= 16) || (e >= 18 && e <= 34) || (e >= 36 && e <= 52);
      want_done = (e == 16) || (e == 34) || (e == 52);
      if (busy1 !== want_busy || e == 17 || e == 18 || e == 53)
        chk($sformatf("hold_busy_e%0d", e), 32'(busy1), 32'(want_busy));
      if (done1 !== want_done || want_done)
        chk($sformatf("hold_done_e%0d", e), 32'(done1), 32'(want_done));
      if (e == 16) begin
        chk("s0_table", 32'(tbl1), 32'h0F0F);
        chk("s0_pass", 32'(pass1), 32'd1);
        chk("s0_cnt", 32'(cnt1), 32'd0);
      end
      if (e == 39) start1 = 1'b0;
      if (e == 44) start1 = 1'b1;
      if (e == 45) start1 = 1'b0;
    end

    // Reset 10 cycles into a sweep, then a fresh sweep completes normally.
    mode = 0;
    @(negedge clk);
    exp0   = 16'h0F0F;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("mid_busy", 32'(busy0), 32'd1);
    reset = 1'b1;
    #1;
    chk_zero0("mid_rst");
    dcount = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done0) dcount++;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done0 || busy0) dcount++;
    end
    chk("no_done_after_rst", 32'(dcount), 32'd0);
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
